withdraw_repeat_ctrl: RTL and testbench

WITHDRAW_REPEAT_CTRL -- requirements
Module: withdraw_repeat_ctrl

---
 rtl/withdraw_repeat_ctrl.sv | 130 +++++++++++++
 tb/tb_withdraw_repeat_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/withdraw_repeat_ctrl.sv
// rtl/withdraw_repeat_ctrl.sv - debounced withdraw button with auto-repeat and balance guard
module withdraw_repeat_ctrl #(
  parameter int BAL_W      = 16,
  parameter int STEP       = 20,
  parameter int DEB_CYC    = 4,
  parameter int REPEAT_DLY = 8,
  parameter int REPEAT_PER = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Down_Button,
  input  logic             load,
  input  logic [BAL_W-1:0] load_value,
  output logic             count_down,
  output logic             denied,
  output logic [BAL_W-1:0] balance,
  output logic [CNT_W-1:0] total
);

  localparam int MAX_A = (DEB_CYC > REPEAT_DLY) ? DEB_CYC : REPEAT_DLY;
  localparam int MAX_C = (MAX_A > REPEAT_PER) ? MAX_A : REPEAT_PER;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0]    DEB_LIM   = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0]    DLY_LIM   = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0]    PER_LIM   = CW'(REPEAT_PER - 1);
  localparam logic [BAL_W-1:0] STEP_V    = BAL_W'(STEP);
  localparam logic [CNT_W-1:0] TOTAL_MAX = '1;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, FIRE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  // Set while the current FIRE/HOLD came from an auto-repeat, selecting the short period.
  logic          from_hold, from_hold_nxt;
  logic          fire_ok;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      from_hold <= 1'b0;
      balance   <= '0;
      total     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      from_hold <= from_hold_nxt;
      if (load) begin
        balance <= load_value;
      end else if (count_down) begin
        balance <= balance - STEP_V;
        if (total != TOTAL_MAX) total <= total + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    from_hold_nxt = from_hold;
    if (load) begin
      state_nxt     = IDLE;
      cnt_nxt       = '0;
      from_hold_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Down_Button) begin
            if (DEB_CYC == 1) begin
              state_nxt     = FIRE;
              cnt_nxt       = '0;
              from_hold_nxt = 1'b0;
            end else begin
              state_nxt = DEBOUNCE;
              cnt_nxt   = CW'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (!Down_Button) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == DEB_LIM) begin
            state_nxt     = FIRE;
            cnt_nxt       = '0;
            from_hold_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        FIRE: begin
          // HOLD is entered with cnt=1 so the next FIRE lands exactly the repeat distance later.
          if (Down_Button) begin
            state_nxt = HOLD;
            cnt_nxt   = CW'(1);
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        HOLD: begin
          if (!Down_Button) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == (from_hold ? PER_LIM : DLY_LIM)) begin
            state_nxt     = FIRE;
            cnt_nxt       = '0;
            from_hold_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A load in the FIRE cycle cancels the withdrawal outright.
  always_comb begin
    fire_ok    = (state == FIRE) && !load;
    count_down = fire_ok && (balance >= STEP_V);
    denied     = fire_ok && (balance < STEP_V);
  end

endmodule

// File: tb/tb_withdraw_repeat_ctrl.sv
// tb/tb_withdraw_repeat_ctrl.sv - scoreboard bench for withdraw_repeat_ctrl
module tb_withdraw_repeat_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Down_Button = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic        count_down, denied;
  logic [15:0] balance;
  logic [7:0]  total;
  logic        cd_s, dn_s;
  logic [15:0] bal_s;
  logic [1:0]  total_s;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {int c; int kind;} pulse_t;
  pulse_t exp_q[$];

  withdraw_repeat_ctrl dut (
    .clk(clk), .reset(reset), .Down_Button(Down_Button), .load(load),
    .load_value(load_value), .count_down(count_down), .denied(denied),
    .balance(balance), .total(total)
  );

  withdraw_repeat_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .Down_Button(Down_Button), .load(load),
    .load_value(load_value), .count_down(cd_s), .denied(dn_s),
    .balance(bal_s), .total(total_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // kind: 1 = count_down, 0 = denied
  always @(negedge clk) begin
    if (count_down === 1'b1 && denied === 1'b1) check("mutex", 1, 0);
    if (count_down === 1'b1 || denied === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", cyc, -1);
      end else begin
        pulse_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.c);
        check("pulse_kind", int'(count_down), e.kind);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int c, input int kind);
    pulse_t e;
    e.c = c;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0; Down_Button = 1'b0; load = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_value = 16'(v);
    step(1);
    load = 1'b0;
  endtask

  int k;

  initial begin
    step(2);
    check("rst_count_down", int'(count_down), 0);
    check("rst_denied", int'(denied), 0);
    check("rst_balance", int'(balance), 0);
    check("rst_total", int'(total), 0);
    reset = 1'b1;

    // single press: 100 -> 80
    do_load(100);
    k = cyc; Down_Button = 1'b1; expect_pulse(k + 4, 1);
    step(4); Down_Button = 1'b0;
    step(4);
    check("single_balance", int'(balance), 80);
    check("single_total", int'(total), 1);
    drain("single_missed");

    // bounce: 3 high, 1 low, 3 high -> nothing
    do_reset(); do_load(100);
    Down_Button = 1'b1; step(3);
    Down_Button = 1'b0; step(1);
    Down_Button = 1'b1; step(3);
    Down_Button = 1'b0; step(4);
    check("bounce_balance", int'(balance), 100);
    check("bounce_total", int'(total), 0);
    drain("bounce_missed");

    // continuous hold with auto-repeat down to zero, then denied
    do_reset(); do_load(100);
    k = cyc; Down_Button = 1'b1;
    expect_pulse(k + 4, 1);  expect_pulse(k + 12, 1); expect_pulse(k + 16, 1);
    expect_pulse(k + 20, 1); expect_pulse(k + 24, 1); expect_pulse(k + 28, 0);
    step(28); Down_Button = 1'b0;
    step(4);
    check("hold_balance", int'(balance), 0);
    check("hold_total", int'(total), 5);
    check("sat_total", int'(total_s), 3);
    drain("hold_missed");

    // insufficient balance
    do_reset(); do_load(15);
    k = cyc; Down_Button = 1'b1; expect_pulse(k + 4, 0);
    step(4); Down_Button = 1'b0;
    step(4);
    check("deny_balance", int'(balance), 15);
    check("deny_total", int'(total), 0);
    drain("deny_missed");

    // load during FIRE cancels it and returns to IDLE; button held forces a fresh debounce
    do_reset(); do_load(100);
    k = cyc; Down_Button = 1'b1;
    step(4);
    load = 1'b1; load_value = 16'd50;
    step(1);
    load = 1'b0;
    check("loadfire_balance", int'(balance), 50);
    check("loadfire_total", int'(total), 0);
    expect_pulse(k + 9, 1);
    step(4); Down_Button = 1'b0;
    step(4);
    check("loadfire_after_balance", int'(balance), 30);
    check("loadfire_after_total", int'(total), 1);
    drain("loadfire_missed");

    // reset in HOLD aborts the repeat
    do_reset(); do_load(100);
    k = cyc; Down_Button = 1'b1; expect_pulse(k + 4, 1);
    step(6);
    reset = 1'b0;
    step(1);
    check("rsthold_count_down", int'(count_down), 0);
    check("rsthold_denied", int'(denied), 0);
    check("rsthold_balance", int'(balance), 0);
    check("rsthold_total", int'(total), 0);
    check("rsthold_sat_total", int'(total_s), 0);
    reset = 1'b1; Down_Button = 1'b0;
    step(20);
    drain("rsthold_missed");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
